// File: rtl/i2c_pkg.sv
// Shared I2C constants used by the data unit and by the I2C controller.
package i2c_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 4;

  // Count value seen when the final bit of a byte is being sampled.
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

endpackage : i2c_pkg

// File: rtl/i2c_edge_detect.sv
// Single-clock-wide rising/falling strobes for the SCL-rate reference clock.
module i2c_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic clock_i2c,
  output logic neg_edge,
  output logic pos_edge
);

  logic clk_prev;

  // Remember last cycle's level of the reference clock so transitions show up as one-cycle strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_prev <= 1'b0;
    end else begin
      clk_prev <= clock_i2c;
    end
  end

  assign neg_edge = clk_prev & ~clock_i2c;
  assign pos_edge = ~clk_prev & clock_i2c;

endmodule : i2c_edge_detect

// File: rtl/i2c_data_unit.sv
// I2C data path: SCL generation, transmit shifter, receive shifter with bit count, and ACK sampling.
module i2c_data_unit
  import i2c_pkg::*;
(
  input  logic              clock,
  input  logic              Reset,
  input  logic              ClockI2C,
  input  logic              BaudEnable,
  input  logic              WriteLoad,
  input  logic              ShiftorHold,
  input  logic              Select,
  input  logic              StartStopAck,
  input  logic              ReadOrWrite,
  input  logic [BYTE_W-1:0] DataIn,
  input  logic              SDAin,
  output logic              SCL,
  output logic              SDAout,
  output logic              SDAoe,
  output logic [BYTE_W-1:0] ReceivedData,
  output logic              DataValid,
  output logic              AckError,
  output logic              AckValid
);

  logic                 neg_edge;
  logic                 pos_edge;
  logic [BYTE_W-1:0]    tx_shift;
  logic [BYTE_W-1:0]    rx_shift;
  logic [BIT_CNT_W-1:0] bit_count;
  logic                 tx_shift_en;
  logic                 rx_sample;
  logic                 ack_sample;
  logic                 last_bit;

  i2c_edge_detect u_edge_detect (
    .clock     (clock),
    .reset     (Reset),
    .clock_i2c (ClockI2C),
    .neg_edge  (neg_edge),
    .pos_edge  (pos_edge)
  );

  // Edges only count while the bus clock is enabled; a load always wins over shifting or sampling.
  assign tx_shift_en = BaudEnable & neg_edge & ShiftorHold & ~ReadOrWrite & ~WriteLoad;
  assign rx_sample   = BaudEnable & pos_edge & ShiftorHold & ReadOrWrite & Select & ~WriteLoad;
  assign ack_sample  = BaudEnable & pos_edge & ReadOrWrite & ~Select & ~ShiftorHold;
  assign last_bit    = (bit_count == LAST_BIT);

  // Registered SCL: follows the reference clock when enabled, otherwise parks high.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      SCL <= 1'b1;
    end else begin
      SCL <= BaudEnable ? ClockI2C : 1'b1;
    end
  end

  // Transmit shifter: load a new byte, or move the next bit to the MSB after each SCL fall.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      tx_shift <= '0;
    end else if (WriteLoad) begin
      tx_shift <= DataIn;
    end else if (tx_shift_en) begin
      tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
    end
  end

  // SDA drive: released (and idling high) while receiving, otherwise data MSB or start/stop/ack level.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      SDAoe  <= 1'b1;
      SDAout <= 1'b1;
    end else begin
      SDAoe  <= ~ReadOrWrite;
      if (ReadOrWrite) begin
        SDAout <= 1'b1;
      end else if (Select) begin
        SDAout <= tx_shift[BYTE_W-1];
      end else begin
        SDAout <= StartStopAck;
      end
    end
  end

  // Receive shifter and bit counter; a load discards any partially received byte.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      rx_shift     <= '0;
      bit_count    <= '0;
      ReceivedData <= '0;
      DataValid    <= 1'b0;
    end else begin
      DataValid <= 1'b0;
      if (WriteLoad) begin
        bit_count <= '0;
      end else if (rx_sample) begin
        rx_shift <= {rx_shift[BYTE_W-2:0], SDAin};
        if (last_bit) begin
          ReceivedData <= {rx_shift[BYTE_W-2:0], SDAin};
          bit_count    <= '0;
          DataValid    <= 1'b1;
        end else begin
          bit_count <= bit_count + BIT_CNT_W'(1);
        end
      end
    end
  end

  // Slave acknowledge capture: SDA high at the SCL rise means NACK.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      AckError <= 1'b0;
      AckValid <= 1'b0;
    end else begin
      AckValid <= ack_sample;
      if (ack_sample) begin
        AckError <= SDAin;
      end
    end
  end

endmodule : i2c_data_unit

// File: tb/tb_i2c_data_unit.sv
// Directed bench for i2c_data_unit: reset, write, read, ACK, load/shift collision, reset mid-read.
module tb_i2c_data_unit;

  logic       clock;
  logic       Reset;
  logic       ClockI2C;
  logic       BaudEnable;
  logic       WriteLoad;
  logic       ShiftorHold;
  logic       Select;
  logic       StartStopAck;
  logic       ReadOrWrite;
  logic [7:0] DataIn;
  logic       SDAin;
  logic       SCL;
  logic       SDAout;
  logic       SDAoe;
  logic [7:0] ReceivedData;
  logic       DataValid;
  logic       AckError;
  logic       AckValid;

  int checks   = 0;
  int failures = 0;
  int dv_count = 0;
  int av_count = 0;
  int oe_bad   = 0;
  int dv_base;
  int av_base;
  logic read_phase;
  logic [7:0] wr_byte;

  i2c_data_unit dut (
    .clock        (clock),
    .Reset        (Reset),
    .ClockI2C     (ClockI2C),
    .BaudEnable   (BaudEnable),
    .WriteLoad    (WriteLoad),
    .ShiftorHold  (ShiftorHold),
    .Select       (Select),
    .StartStopAck (StartStopAck),
    .ReadOrWrite  (ReadOrWrite),
    .DataIn       (DataIn),
    .SDAin        (SDAin),
    .SCL          (SCL),
    .SDAout       (SDAout),
    .SDAoe        (SDAoe),
    .ReceivedData (ReceivedData),
    .DataValid    (DataValid),
    .AckError     (AckError),
    .AckValid     (AckValid)
  );

  // 8 ns system clock.
  initial begin
    clock = 1'b0;
    forever #4 clock = ~clock;
  end

  // 24 ns reference clock, offset so its transitions never coincide with a system clock edge.
  initial begin
    ClockI2C = 1'b0;
    #2;
    forever #12 ClockI2C = ~ClockI2C;
  end

  // Count cycles with DataValid / AckValid high, and any cycle SDA is driven during a read.
  always @(posedge clock) begin
    if (DataValid) dv_count <= dv_count + 1;
    if (AckValid) av_count <= av_count + 1;
    if (read_phase && SDAoe) oe_bad <= oe_bad + 1;
  end

  // Runaway guard.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present the top n bits of b on SDAin MSB first, one per reference-clock rise, then stop the bus clock.
  task automatic applyStimulus(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ClockI2C);
      @(negedge clock);
      SDAin      = b[7-i];
      BaudEnable = 1'b1;
    end
    @(posedge ClockI2C);
    repeat (3) @(negedge clock);
    BaudEnable = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    Reset        = 1'b1;
    BaudEnable   = 1'b0;
    WriteLoad    = 1'b0;
    ShiftorHold  = 1'b0;
    Select       = 1'b0;
    StartStopAck = 1'b1;
    ReadOrWrite  = 1'b0;
    DataIn       = 8'h00;
    SDAin        = 1'b1;
    read_phase   = 1'b0;
    wr_byte      = 8'hA5;

    #3;
    checkOutput("rst_scl", SCL, 1);
    checkOutput("rst_sdaout", SDAout, 1);
    checkOutput("rst_sdaoe", SDAoe, 1);
    checkOutput("rst_rxdata", ReceivedData, 8'h00);
    checkOutput("rst_dvalid", DataValid, 0);
    checkOutput("rst_ackerr", AckError, 0);
    checkOutput("rst_ackvalid", AckValid, 0);
    #3 Reset = 1'b0;

    // Write 0xA5: load while the bus clock is stopped, then shift one bit per SCL fall.
    @(negedge clock);
    DataIn      = 8'hA5;
    WriteLoad   = 1'b1;
    ShiftorHold = 1'b1;
    Select      = 1'b1;
    ReadOrWrite = 1'b0;
    @(negedge clock);
    WriteLoad = 1'b0;
    @(negedge clock);
    checkOutput("wr_bit7", SDAout, 1);
    checkOutput("wr_oe", SDAoe, 1);
    @(posedge ClockI2C);
    @(negedge clock);
    BaudEnable = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(negedge ClockI2C);
      @(negedge clock);
      checkOutput("wr_hold_prev", SDAout, wr_byte[8-k]);
      @(negedge clock);
      checkOutput("wr_scl_low", SCL, 0);
      @(negedge clock);
      checkOutput("wr_bit", SDAout, wr_byte[7-k]);
      checkOutput("wr_scl_high", SCL, 1);
      checkOutput("wr_oe_hold", SDAoe, 1);
    end
    BaudEnable = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("scl_parked", SCL, 1);

    // Read 0x3C.
    ReadOrWrite = 1'b1;
    Select      = 1'b1;
    ShiftorHold = 1'b1;
    repeat (2) @(negedge clock);
    read_phase = 1'b1;
    checkOutput("rd_oe", SDAoe, 0);
    checkOutput("rd_sdaout", SDAout, 1);
    dv_base = dv_count;
    applyStimulus(8'h3C, 7);
    checkOutput("rd_partial_data", ReceivedData, 8'h00);
    checkOutput("rd_partial_dv", dv_count - dv_base, 0);
    applyStimulus(8'h00, 1);
    checkOutput("rd_data", ReceivedData, 8'h3C);
    checkOutput("rd_dv_pulses", dv_count - dv_base, 1);
    checkOutput("rd_oe_driven_cycles", oe_bad, 0);
    read_phase = 1'b0;

    // ACK sampling: NACK then ACK.
    Select      = 1'b0;
    ShiftorHold = 1'b0;
    av_base     = av_count;
    applyStimulus(8'h80, 1);
    checkOutput("ack_nack", AckError, 1);
    checkOutput("ack_pulse1", av_count - av_base, 1);
    checkOutput("ack_rxdata_kept", ReceivedData, 8'h3C);
    checkOutput("ack_no_dv", dv_count - dv_base, 1);
    applyStimulus(8'h00, 1);
    checkOutput("ack_ack", AckError, 0);
    checkOutput("ack_pulse2", av_count - av_base, 2);

    // Load coincident with a falling-edge strobe: load must win, byte stays unshifted.
    ReadOrWrite = 1'b0;
    Select      = 1'b1;
    ShiftorHold = 1'b1;
    DataIn      = 8'h81;
    BaudEnable  = 1'b1;
    @(negedge clock);
    @(negedge ClockI2C);
    #1 WriteLoad = 1'b1;
    @(posedge clock);
    #1 WriteLoad = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("coll_msb", SDAout, 1);
    @(negedge ClockI2C);
    repeat (3) @(negedge clock);
    checkOutput("coll_bit6", SDAout, 0);
    BaudEnable = 1'b0;

    // Reset after four received bits, then a full 0xF0.
    ReadOrWrite = 1'b1;
    Select      = 1'b1;
    ShiftorHold = 1'b1;
    @(negedge clock);
    applyStimulus(8'hA0, 4);
    Reset = 1'b1;
    #1;
    checkOutput("mid_rst_rxdata", ReceivedData, 8'h00);
    checkOutput("mid_rst_oe", SDAoe, 1);
    @(negedge clock);
    Reset = 1'b0;
    @(negedge clock);
    dv_base = dv_count;
    applyStimulus(8'hF0, 7);
    checkOutput("post_rst_partial_data", ReceivedData, 8'h00);
    checkOutput("post_rst_partial_dv", dv_count - dv_base, 0);
    applyStimulus(8'h00, 1);
    checkOutput("post_rst_data", ReceivedData, 8'hF0);
    checkOutput("post_rst_dv", dv_count - dv_base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_i2c_data_unit
